// File: rtl/l1_tlb_refill_pkg.sv
// Shared sizes and refill FSM state encoding for the L1 TLB refill slice.
package l1_tlb_pkg;

  localparam int ENTRIES = 8;
  localparam int ASID_W  = 7;
  localparam int VPN_W   = 27;
  localparam int PPN_W   = 20;
  localparam int TAG_W   = ASID_W + VPN_W;
  localparam int IDX_W   = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    S_READY,
    S_REQUEST,
    S_WAIT,
    S_WAIT_INV
  } state_e;

endpackage

// File: rtl/l1_tlb_refill_if.sv
// Requester, lookup-stage and PTW signals of the L1 TLB refill controller.
interface l1_tlb_refill_if;
  import l1_tlb_pkg::*;

  logic                     io_req_valid;
  logic                     io_req_ready;
  logic [VPN_W-1:0]         io_req_bits_vpn;
  logic [ASID_W-1:0]        io_ptw_ptbr_asid;
  logic                     tlb_miss;
  logic [ENTRIES:0]         hits;
  logic                     io_ptw_req_valid;
  logic                     io_ptw_req_ready;
  logic [VPN_W-1:0]         io_ptw_req_bits_addr;
  logic                     io_ptw_resp_valid;
  logic                     io_ptw_resp_bits_error;
  logic [PPN_W-1:0]         io_ptw_resp_bits_pte_ppn;
  logic                     io_ptw_invalidate;
  logic [ENTRIES*TAG_W-1:0] tags_flat;
  logic [ENTRIES-1:0]       valid;
  logic [ENTRIES*PPN_W-1:0] ppns_flat;

  modport slave (
    input  io_req_valid, io_req_bits_vpn, io_ptw_ptbr_asid, tlb_miss, hits,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_error,
           io_ptw_resp_bits_pte_ppn, io_ptw_invalidate,
    output io_req_ready, io_ptw_req_valid, io_ptw_req_bits_addr,
           tags_flat, valid, ppns_flat
  );

  modport master (
    output io_req_valid, io_req_bits_vpn, io_ptw_ptbr_asid, tlb_miss, hits,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_error,
           io_ptw_resp_bits_pte_ppn, io_ptw_invalidate,
    input  io_req_ready, io_ptw_req_valid, io_ptw_req_bits_addr,
           tags_flat, valid, ppns_flat
  );

endinterface

// File: rtl/l1_tlb_refill_plru.sv
// Tree pseudo-LRU state for the L1 TLB: heap-ordered node bits, touch update, victim walk.
module l1_tlb_plru
  import l1_tlb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch_vld,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim_idx
);

  logic [ENTRIES-2:0] plru;
  logic [ENTRIES-2:0] plru_nxt;
  logic [IDX_W-1:0]   vic_node;
  logic [IDX_W-1:0]   tch_node;
  logic               tch_bit;

  // A node bit of 1 steers the victim into the upper subtree.
  always_comb begin
    vic_node   = '0;
    victim_idx = '0;
    for (int l = 0; l < IDX_W; l++) begin
      victim_idx[IDX_W-1-l] = plru[vic_node];
      vic_node = vic_node + vic_node + IDX_W'(1) + IDX_W'(plru[vic_node]);
    end
  end

  // Touching an entry makes every node on its path point at the other subtree.
  always_comb begin
    plru_nxt = plru;
    tch_node = '0;
    tch_bit  = 1'b0;
    if (touch_vld) begin
      for (int l = 0; l < IDX_W; l++) begin
        tch_bit            = touch_idx[IDX_W-1-l];
        plru_nxt[tch_node] = ~tch_bit;
        tch_node = tch_node + tch_node + IDX_W'(1) + IDX_W'(tch_bit);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) plru <= '0;
    else          plru <= plru_nxt;
  end

endmodule

// File: rtl/l1_tlb_refill.sv
// L1 TLB refill controller: entry storage, miss-driven PTW walk FSM, invalid-first/PLRU victim.
module l1_tlb_refill
  import l1_tlb_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  l1_tlb_refill_if.slave  bus
);

  state_e             state;
  logic [TAG_W-1:0]   r_refill_tag;
  logic [IDX_W-1:0]   r_refill_idx;
  logic               req_ready_q;
  logic               ptw_req_valid_q;

  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [PPN_W-1:0]   ppns [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic               install;
  logic               hit_touch;
  logic [IDX_W-1:0]   hit_idx;
  logic               touch_vld;
  logic [IDX_W-1:0]   touch_idx;
  logic [IDX_W-1:0]   plru_victim;
  logic [IDX_W-1:0]   inv_idx;
  logic               any_inv;
  logic [IDX_W-1:0]   victim;
  logic               vm_off_unused;

  // The vm-disabled hit line is a lookup-stage bypass and never ages entries.
  assign vm_off_unused = bus.hits[ENTRIES];

  assign install = (state == S_WAIT) && bus.io_ptw_resp_valid &&
                   !bus.io_ptw_invalidate && !bus.io_ptw_resp_bits_error;
  assign hit_touch = (state == S_READY) && bus.io_req_valid && (|bus.hits[ENTRIES-1:0]);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (bus.hits[i]) hit_idx = hit_idx | IDX_W'(i);
  end

  assign touch_vld = install || hit_touch;
  assign touch_idx = install ? r_refill_idx : hit_idx;

  l1_tlb_plru u_plru (
    .clk        (clk),
    .reset_n    (reset_n),
    .touch_vld  (touch_vld),
    .touch_idx  (touch_idx),
    .victim_idx (plru_victim)
  );

  // Prefer the lowest free slot; only age out a live entry when the TLB is full.
  always_comb begin
    inv_idx = '0;
    any_inv = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_idx = IDX_W'(i);
        any_inv = 1'b1;
      end
    end
  end

  assign victim = any_inv ? inv_idx : plru_victim;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_READY;
      r_refill_tag    <= '0;
      r_refill_idx    <= '0;
      req_ready_q     <= 1'b1;
      ptw_req_valid_q <= 1'b0;
    end else begin
      case (state)
        S_READY: begin
          if (bus.io_req_valid && bus.tlb_miss) begin
            r_refill_tag    <= {bus.io_ptw_ptbr_asid, bus.io_req_bits_vpn};
            r_refill_idx    <= victim;
            state           <= S_REQUEST;
            req_ready_q     <= 1'b0;
            ptw_req_valid_q <= 1'b1;
          end
        end
        S_REQUEST: begin
          if (bus.io_ptw_invalidate) begin
            state           <= S_READY;
            req_ready_q     <= 1'b1;
            ptw_req_valid_q <= 1'b0;
          end else if (bus.io_ptw_req_ready) begin
            state           <= S_WAIT;
            ptw_req_valid_q <= 1'b0;
          end
        end
        // An sfence during the walk must still swallow the walk's eventual response.
        S_WAIT: begin
          if (bus.io_ptw_invalidate) begin
            state <= S_WAIT_INV;
          end else if (bus.io_ptw_resp_valid) begin
            state       <= S_READY;
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT_INV: begin
          if (bus.io_ptw_resp_valid) begin
            state       <= S_READY;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state           <= S_READY;
          req_ready_q     <= 1'b1;
          ptw_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        ppns[i] <= '0;
      end
    end else begin
      if (bus.io_ptw_invalidate) valid_q <= '0;
      else if (install)          valid_q[r_refill_idx] <= 1'b1;
      if (install) begin
        tags[r_refill_idx] <= r_refill_tag;
        ppns[r_refill_idx] <= bus.io_ptw_resp_bits_pte_ppn;
      end
    end
  end

  assign bus.io_req_ready         = req_ready_q;
  assign bus.io_ptw_req_valid     = ptw_req_valid_q;
  assign bus.io_ptw_req_bits_addr = r_refill_tag[VPN_W-1:0];
  assign bus.valid                = valid_q;

  always_comb begin
    bus.tags_flat = '0;
    bus.ppns_flat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      bus.tags_flat[i*TAG_W +: TAG_W] = tags[i];
      bus.ppns_flat[i*PPN_W +: PPN_W] = ppns[i];
    end
  end

endmodule

// File: tb/tb_l1_tlb_refill.sv
// Directed bench for l1_tlb_refill: refill flow, PLRU victim choice, sfence races, walk errors, async reset.
module tb_l1_tlb_refill;
  import l1_tlb_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  l1_tlb_refill_if bus ();

  l1_tlb_refill dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TAG_W-1:0] mk_tag(input logic [ASID_W-1:0] a, input logic [VPN_W-1:0] v);
    return {a, v};
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input int i);
    return bus.tags_flat[i*TAG_W +: TAG_W];
  endfunction

  function automatic logic [PPN_W-1:0] ppn_of(input int i);
    return bus.ppns_flat[i*PPN_W +: PPN_W];
  endfunction

  task automatic idle_inputs();
    bus.io_req_valid             = 1'b0;
    bus.io_req_bits_vpn          = '0;
    bus.io_ptw_ptbr_asid         = 7'd3;
    bus.tlb_miss                 = 1'b0;
    bus.hits                     = '0;
    bus.io_ptw_req_ready         = 1'b0;
    bus.io_ptw_resp_valid        = 1'b0;
    bus.io_ptw_resp_bits_error   = 1'b0;
    bus.io_ptw_resp_bits_pte_ppn = '0;
    bus.io_ptw_invalidate        = 1'b0;
  endtask

  task automatic miss_req(input logic [VPN_W-1:0] vpn);
    bus.io_req_valid    = 1'b1;
    bus.io_req_bits_vpn = vpn;
    bus.tlb_miss        = 1'b1;
    bus.hits            = '0;
    tick();
    bus.io_req_valid = 1'b0;
    bus.tlb_miss     = 1'b0;
  endtask

  // Miss, one-cycle PTW accept, single-cycle response.
  task automatic refill(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn, input logic err);
    miss_req(vpn);
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready         = 1'b0;
    bus.io_ptw_resp_valid        = 1'b1;
    bus.io_ptw_resp_bits_error   = err;
    bus.io_ptw_resp_bits_pte_ppn = ppn;
    tick();
    bus.io_ptw_resp_valid      = 1'b0;
    bus.io_ptw_resp_bits_error = 1'b0;
  endtask

  task automatic hit_req(input int i);
    bus.io_req_valid = 1'b1;
    bus.hits         = '0;
    bus.hits[i]      = 1'b1;
    tick();
    bus.io_req_valid = 1'b0;
    bus.hits         = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    chk("rst_valid", 64'(bus.valid), 64'h0);
    chk("rst_req_ready", 64'(bus.io_req_ready), 64'h1);
    chk("rst_ptw_valid", 64'(bus.io_ptw_req_valid), 64'h0);
    chk("rst_tags_zero", 64'(|bus.tags_flat), 64'h0);

    // First miss and refill into entry 0
    miss_req(27'h1234);
    chk("t1_ptw_valid", 64'(bus.io_ptw_req_valid), 64'h1);
    chk("t1_ptw_addr", 64'(bus.io_ptw_req_bits_addr), 64'h1234);
    chk("t1_req_ready", 64'(bus.io_req_ready), 64'h0);
    tick();
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready = 1'b0;
    chk("t1_wait_ptw_valid", 64'(bus.io_ptw_req_valid), 64'h0);
    bus.io_ptw_resp_valid        = 1'b1;
    bus.io_ptw_resp_bits_pte_ppn = 20'hABCDE;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    chk("t1_tag0", 64'(tag_of(0)), 64'(mk_tag(7'd3, 27'h1234)));
    chk("t1_ppn0", 64'(ppn_of(0)), 64'hABCDE);
    chk("t1_valid", 64'(bus.valid), 64'h01);
    chk("t1_req_ready", 64'(bus.io_req_ready), 64'h1);

    // Fill entries 1..7 through the lowest-free rule
    for (int i = 1; i < 8; i++) refill(27'h100 + 27'(i), 20'h100 + 20'(i), 1'b0);
    chk("t2_valid_full", 64'(bus.valid), 64'hFF);
    chk("t2_tag7", 64'(tag_of(7)), 64'(mk_tag(7'd3, 27'h107)));
    chk("t2_ppn5", 64'(ppn_of(5)), 64'h105);

    // After hitting 0..6 the tree points lower/lower/lower -> entry 0
    for (int i = 0; i < 7; i++) hit_req(i);
    refill(27'h2000, 20'h22222, 1'b0);
    chk("t2_victim0_tag", 64'(tag_of(0)), 64'(mk_tag(7'd3, 27'h2000)));
    chk("t2_victim0_ppn", 64'(ppn_of(0)), 64'h22222);
    chk("t2_tag7_kept", 64'(tag_of(7)), 64'(mk_tag(7'd3, 27'h107)));

    // Install of 0 set t0,t1,t3; hit 7 clears t0,t2,t6; t4 from hit 3 is 0 -> entry 2
    hit_req(7);
    refill(27'h2001, 20'h33333, 1'b0);
    chk("t2_victim2_tag", 64'(tag_of(2)), 64'(mk_tag(7'd3, 27'h2001)));
    chk("t2_tag1_kept", 64'(tag_of(1)), 64'(mk_tag(7'd3, 27'h101)));

    // Sfence racing the response in S_WAIT (PLRU victim would be entry 4)
    miss_req(27'h3333);
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready         = 1'b0;
    bus.io_ptw_resp_valid        = 1'b1;
    bus.io_ptw_resp_bits_pte_ppn = 20'h44444;
    bus.io_ptw_invalidate        = 1'b1;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    bus.io_ptw_invalidate = 1'b0;
    chk("t3_valid_flushed", 64'(bus.valid), 64'h00);
    chk("t3_tag4_kept", 64'(tag_of(4)), 64'(mk_tag(7'd3, 27'h104)));
    chk("t3_ppn4_kept", 64'(ppn_of(4)), 64'h104);
    chk("t3_wait_inv_ready", 64'(bus.io_req_ready), 64'h0);
    tick();
    chk("t3_still_waiting", 64'(bus.io_req_ready), 64'h0);
    bus.io_ptw_resp_valid        = 1'b1;
    bus.io_ptw_resp_bits_pte_ppn = 20'h55555;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    chk("t3_back_ready", 64'(bus.io_req_ready), 64'h1);
    chk("t3_no_install", 64'(bus.valid), 64'h00);

    // PTW stalls in S_REQUEST, then sfence drops the request
    miss_req(27'h5555);
    for (int c = 0; c < 5; c++) begin
      chk("t4_addr_stable", 64'(bus.io_ptw_req_bits_addr), 64'h5555);
      chk("t4_req_ready_low", 64'(bus.io_req_ready), 64'h0);
      tick();
    end
    chk("t4_ptw_valid_held", 64'(bus.io_ptw_req_valid), 64'h1);
    bus.io_ptw_invalidate = 1'b1;
    tick();
    bus.io_ptw_invalidate = 1'b0;
    chk("t4_req_ready", 64'(bus.io_req_ready), 64'h1);
    chk("t4_ptw_valid_drop", 64'(bus.io_ptw_req_valid), 64'h0);
    chk("t4_valid", 64'(bus.valid), 64'h00);

    // Faulting walk installs nothing
    refill(27'h7777, 20'h77777, 1'b0);
    chk("t5_valid_one", 64'(bus.valid), 64'h01);
    refill(27'h6666, 20'h11111, 1'b1);
    chk("t5_err_valid", 64'(bus.valid), 64'h01);
    chk("t5_err_tag1_kept", 64'(tag_of(1)), 64'(mk_tag(7'd3, 27'h101)));
    chk("t5_err_ready", 64'(bus.io_req_ready), 64'h1);

    // Refill 1..7 leaves all tree bits 0; a vm-disabled hit must not disturb that
    for (int i = 1; i < 8; i++) refill(27'h400 + 27'(i), 20'h400 + 20'(i), 1'b0);
    chk("t5_full", 64'(bus.valid), 64'hFF);
    bus.io_req_valid = 1'b1;
    bus.hits         = 9'h100;
    tick();
    bus.io_req_valid = 1'b0;
    bus.hits         = '0;
    chk("t5_vmoff_ready", 64'(bus.io_req_ready), 64'h1);
    refill(27'h8888, 20'h88888, 1'b0);
    chk("t5_vmoff_victim0", 64'(tag_of(0)), 64'(mk_tag(7'd3, 27'h8888)));
    chk("t5_tag4_kept", 64'(tag_of(4)), 64'(mk_tag(7'd3, 27'h404)));

    // Async reset while waiting on the PTW
    miss_req(27'h9999);
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.valid), 64'h00);
    chk("t6_rst_ready", 64'(bus.io_req_ready), 64'h1);
    chk("t6_rst_ptw_valid", 64'(bus.io_ptw_req_valid), 64'h0);
    chk("t6_rst_tag0", 64'(tag_of(0)), 64'h0);
    chk("t6_rst_addr", 64'(bus.io_ptw_req_bits_addr), 64'h0);
    tick();
    reset_n = 1'b1;
    bus.io_ptw_resp_valid        = 1'b1;
    bus.io_ptw_resp_bits_pte_ppn = 20'h99999;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    chk("t6_late_resp_valid", 64'(bus.valid), 64'h00);
    chk("t6_late_resp_ppn0", 64'(ppn_of(0)), 64'h0);
    chk("t6_ready", 64'(bus.io_req_ready), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
